// File: rtl/mult_seq_controller.sv
// Sequencing FSM for the shift-add multiplier datapath.
// Handles load, WIDTH iterations, a done pulse, and abort/reset.
module mult_seq_controller #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH+1)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Abort,
   output logic          a_sel,
   output logic          b_sel,
   output logic          prod_sel,
   output logic          Shift_Enable,
   output logic          Busy,
   output logic          Done,
   output logic          Prod_Valid,
   output logic [CW-1:0] Iter_Count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t     state;
   logic [5:0] ctl;

   // Output bundle {a_sel,b_sel,prod_sel,Shift_Enable,Busy,Done} per state
   function automatic logic [5:0] ctl_of(input state_t s);
      logic [5:0] c;
      c = 6'b000000;
      case (s)
         IDLE: c = 6'b000000;
         LOAD: c = 6'b111010;
         ITER: c = 6'b000110;
         DONE: c = 6'b000001;
      endcase
      return c;
   endfunction

   assign {a_sel, b_sel, prod_sel, Shift_Enable, Busy, Done} = ctl;

   // State, iteration counter and registered outputs advance together
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         ctl        <= ctl_of(IDLE);
         Iter_Count <= '0;
         Prod_Valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  state      <= LOAD;
                  ctl        <= ctl_of(LOAD);
                  Iter_Count <= '0;
                  Prod_Valid <= 1'b0;
               end
            end
            LOAD: begin
               if (Abort) begin
                  state      <= IDLE;
                  ctl        <= ctl_of(IDLE);
                  Iter_Count <= '0;
                  Prod_Valid <= 1'b0;
               end else begin
                  state <= ITER;
                  ctl   <= ctl_of(ITER);
               end
            end
            ITER: begin
               if (Abort) begin
                  state      <= IDLE;
                  ctl        <= ctl_of(IDLE);
                  Iter_Count <= '0;
                  Prod_Valid <= 1'b0;
               end else if (Iter_Count == LAST) begin
                  state      <= DONE;
                  ctl        <= ctl_of(DONE);
                  Iter_Count <= Iter_Count + ONE;
               end else begin
                  Iter_Count <= Iter_Count + ONE;
               end
            end
            DONE: begin
               state      <= IDLE;
               ctl        <= ctl_of(IDLE);
               Prod_Valid <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_controller.sv
// Self-checking bench for mult_seq_controller with a shift-add
// datapath model driven by the controller outputs.
module tb_mult_seq_controller;

   localparam int WIDTH = 32;
   localparam int CW    = $clog2(WIDTH+1);

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic          Abort = 1'b0;
   logic          a_sel, b_sel, prod_sel;
   logic          Shift_Enable, Busy, Done, Prod_Valid;
   logic [CW-1:0] Iter_Count;

   logic [31:0] data_a = '0;
   logic [31:0] data_b = '0;
   logic [63:0] dp_a, dp_b, dp_p;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int cyc      = 0;

   mult_seq_controller #(.WIDTH(WIDTH)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
      .a_sel(a_sel), .b_sel(b_sel), .prod_sel(prod_sel),
      .Shift_Enable(Shift_Enable), .Busy(Busy), .Done(Done),
      .Prod_Valid(Prod_Valid), .Iter_Count(Iter_Count)
   );

   always #5 Clock = ~Clock;

   // Reference shift-add datapath steered by the controller
   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (Done) done_cnt <= done_cnt + 1;
      if (a_sel) dp_a <= {32'd0, data_a};
      else if (Shift_Enable) dp_a <= dp_a << 1;
      if (b_sel) dp_b <= {32'd0, data_b};
      else if (Shift_Enable) dp_b <= dp_b >> 1;
      if (prod_sel) dp_p <= '0;
      else if (Shift_Enable && dp_b[0]) dp_p <= dp_p + dp_a;
   end

   function automatic logic [12:0] outs();
      return {a_sel, b_sel, prod_sel, Shift_Enable, Busy, Done,
              Prod_Valid, Iter_Count};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic wait_cnt(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (int'(Iter_Count) == target && Busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_p, input string tag);
      int edges;
      int se;
      data_a = a;
      data_b = b;
      Start  = 1'b1;
      tick();
      Start = 1'b0;
      edges = 1;
      se    = 0;
      chk({tag, "_load"}, 64'(outs()), 64'(13'b1110100_000000));
      while (!Done && edges < 60) begin
         tick();
         edges++;
         if (Shift_Enable) se++;
      end
      chk({tag, "_latency"}, 64'(edges), 64'd34);
      chk({tag, "_shift_cycles"}, 64'(se), 64'd32);
      chk({tag, "_product"}, dp_p, exp_p);
      chk({tag, "_cnt_done"}, 64'(Iter_Count), 64'd32);
      chk({tag, "_pv_in_done"}, 64'(Prod_Valid), 64'd0);
      tick();
      chk({tag, "_after"}, 64'(outs()), 64'(13'b0000001_100000));
      chk({tag, "_product_hold"}, dp_p, exp_p);
   endtask

   typedef struct {
      logic        rst;
      logic        start;
      logic        abort;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      bit ok;
      int d0;
      int t[3];
      int nd;

      vecs[0]  = '{1, 0, 0, 13'b0000000_000000};
      vecs[1]  = '{1, 0, 0, 13'b0000000_000000};
      vecs[2]  = '{0, 0, 0, 13'b0000000_000000};
      vecs[3]  = '{0, 1, 1, 13'b1110100_000000};
      vecs[4]  = '{0, 0, 1, 13'b0000000_000000};
      vecs[5]  = '{0, 1, 0, 13'b1110100_000000};
      vecs[6]  = '{0, 0, 0, 13'b0001100_000000};
      vecs[7]  = '{0, 0, 0, 13'b0001100_000001};
      vecs[8]  = '{0, 1, 0, 13'b0001100_000010};
      vecs[9]  = '{0, 0, 1, 13'b0000000_000000};
      vecs[10] = '{0, 0, 0, 13'b0000000_000000};
      vecs[11] = '{0, 1, 0, 13'b1110100_000000};
      vecs[12] = '{1, 0, 0, 13'b0000000_000000};

      @(negedge Clock);
      for (int i = 0; i < 13; i++) begin
         Reset = vecs[i].rst;
         Start = vecs[i].start;
         Abort = vecs[i].abort;
         tick();
         chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      end
      Reset = 1'b0;
      Start = 1'b0;
      Abort = 1'b0;

      d0 = done_cnt;
      repeat (10) tick();
      chk("idle_quiet", 64'(outs()), 64'd0);
      chk("idle_no_done", 64'(done_cnt - d0), 64'd0);

      run_mult(32'd3, 32'd5, 64'd15, "m3x5");
      run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "mff");

      // Abort at Iter_Count=10
      Start = 1'b1;
      tick();
      Start = 1'b0;
      d0 = done_cnt;
      wait_cnt(10, ok);
      chk("abort_reach10", 64'(ok), 64'd1);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      chk("abort_idle", 64'(outs()), 64'd0);
      repeat (40) tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run_mult(32'd7, 32'd9, 64'd63, "post_abort");

      // Reset mid-iteration
      Start = 1'b1;
      tick();
      Start = 1'b0;
      d0 = done_cnt;
      wait_cnt(20, ok);
      chk("rst_reach20", 64'(ok), 64'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("rst_mid_iter", 64'(outs()), 64'd0);
      repeat (40) tick();
      chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

      // Start held high: back-to-back operations
      nd = 0;
      Start = 1'b1;
      for (int i = 0; i < 200 && nd < 3; i++) begin
         tick();
         if (Done) begin
            t[nd] = cyc;
            nd++;
         end
      end
      Start = 1'b0;
      chk("b2b_count", 64'(nd), 64'd3);
      if (nd == 3) begin
         chk("b2b_gap1", 64'(t[1] - t[0]), 64'd35);
         chk("b2b_gap2", 64'(t[2] - t[1]), 64'd35);
      end
      tick();

      // Start pulse while busy is ignored
      Start = 1'b1;
      tick();
      Start = 1'b0;
      d0 = done_cnt;
      wait_cnt(5, ok);
      chk("busy_reach5", 64'(ok), 64'd1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("busy_start_cnt", 64'(Iter_Count), 64'd6);
      repeat (60) tick();
      chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

      // Abort during DONE has no effect
      data_a = 32'd6;
      data_b = 32'd7;
      Start  = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 60 && !Done; i++) tick();
      chk("abort_done_pulse", 64'(Done), 64'd1);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      chk("abort_done_pv", 64'(outs()), 64'(13'b0000001_100000));
      chk("abort_done_prod", dp_p, 64'd42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
